// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder used as the serial datapath.
// Latency: combinational. Backpressure: none.
// Flow: no handshake; pure function of its inputs.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial {co,sum} = a + b + ci, LSB first, one bit per clock.
// Latency: out_valid rises WIDTH cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t          state_q,  state_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic            carry_q,  carry_d;
    logic            co_q,     co_d;
    logic [CW-1:0]   cnt_q,    cnt_d;

    logic fa_s;
    logic fa_co;

    fa_cell u_fa (
        .a  (a_q[cnt_q]),
        .b  (b_q[cnt_q]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    sum_d   = '0;
                    co_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[cnt_q] = fa_s;
                carry_d      = fa_co;
                if (cnt_q == LAST_BIT) begin
                    // Counter stops here rather than wrapping; DONE ignores it.
                    co_d    = fa_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // Handshake edge only returns to IDLE; acceptance waits a cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        co        = co_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, ci, out_valid, out_ready, co;
    logic [7:0]  a, b, sum;

    logic        in_valid16, in_ready16, ci16, out_valid16, out_ready16, co16;
    logic [15:0] a16, b16, sum16;

    int n_tests;
    int n_fail;
    int hs_cnt;
    int overlap_cnt;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .ci        (ci16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .co        (co16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_cnt++;
    end

    always @(negedge clk) begin
        if (in_ready && out_valid) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic civ,
                          input bit check_hs,
                          output logic [7:0] s, output logic c, output int lat);
        int waitc;
        waitc = 0;
        s = '0;
        c = 1'b0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        a = av; b = bv; ci = civ;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
        s = sum;
        c = co;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (check_hs) begin
            chk("hs_in_ready", 32'(in_ready), 32'd1);
            chk("hs_out_valid", 32'(out_valid), 32'd0);
        end
    endtask

    logic [7:0] rs;
    logic       rc;
    int         rl;

    initial begin
        n_tests = 0; n_fail = 0; hs_cnt = 0; overlap_cnt = 0;
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = '0; b = '0; ci = 0;
        in_valid16 = 0; out_ready16 = 0; a16 = '0; b16 = '0; ci16 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst16_in_ready", 32'(in_ready16), 32'd1);
        chk("rst16_out_valid", 32'(out_valid16), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, expected values worked by hand.
        do_add(8'hFF, 8'h01, 1'b0, 1'b1, rs, rc, rl);
        chk("ff_01_sum", 32'(rs), 32'h00);
        chk("ff_01_co", 32'(rc), 32'd1);
        chk("ff_01_lat", 32'(rl), 32'd8);
        do_add(8'h00, 8'h00, 1'b0, 1'b1, rs, rc, rl);
        chk("zero_sum", 32'(rs), 32'h00);
        chk("zero_co", 32'(rc), 32'd0);
        do_add(8'hFF, 8'hFF, 1'b1, 1'b1, rs, rc, rl);
        chk("ones_sum", 32'(rs), 32'hFF);
        chk("ones_co", 32'(rc), 32'd1);
        do_add(8'h7F, 8'h01, 1'b0, 1'b1, rs, rc, rl);
        chk("7f_01_sum", 32'(rs), 32'h80);
        chk("7f_01_co", 32'(rc), 32'd0);
        do_add(8'hA5, 8'h5A, 1'b1, 1'b1, rs, rc, rl);
        chk("a5_5a_sum", 32'(rs), 32'h00);
        chk("a5_5a_co", 32'(rc), 32'd1);

        // Sampled sweep across the operand space.
        begin
            int hs0;
            hs0 = hs_cnt;
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    for (int cv = 0; cv < 2; cv++) begin
                        logic [7:0] av, bv;
                        logic [8:0] ex;
                        av = 8'(ai * 17);
                        bv = 8'((bi * 37) ^ 8'hA5);
                        ex = 9'(av) + 9'(bv) + 9'(cv);
                        do_add(av, bv, cv[0], 1'b0, rs, rc, rl);
                        chk("sweep", {23'd0, rc, rs}, {23'd0, ex});
                    end
                end
            end
            chk("sweep_count", 32'(hs_cnt - hs0), 32'd512);
        end

        // Hold in DONE with the consumer stalled and the inputs wiggling.
        a = 8'hC3; b = 8'h5A; ci = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        begin
            int w;
            w = 0;
            while (!out_valid && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            chk("hold_lat", 32'(w), 32'd8);
        end
        for (int k = 0; k < 5; k++) begin
            a = ~a; b = ~b; in_valid = ~in_valid;
            @(posedge clk); #1;
            chk("hold_sum", 32'(sum), 32'h1E);
            chk("hold_co", 32'(co), 32'd1);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_release", 32'(in_ready), 32'd1);

        // Reset in the middle of RUN, after bits 0..2 have been processed.
        a = 8'hAA; b = 8'h55; ci = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_co", 32'(co), 32'd0);
        do_add(8'h12, 8'h34, 1'b0, 1'b1, rs, rc, rl);
        chk("post_abort_sum", 32'(rs), 32'h46);
        chk("post_abort_co", 32'(rc), 32'd0);

        // Continuous streaming: one accept every WIDTH+2 cycles.
        begin
            int acc[$];
            a = 8'h21; b = 8'h42; ci = 1'b0;
            in_valid = 1'b1; out_ready = 1'b1;
            overlap_cnt = 0;
            for (int cyc = 0; cyc < 50; cyc++) begin
                if (in_ready) acc.push_back(cyc);
                if (out_valid) chk("stream_sum", {23'd0, co, sum}, 32'h063);
                @(posedge clk); #1;
            end
            in_valid = 1'b0; out_ready = 1'b0;
            chk("stream_accepts", 32'(acc.size()), 32'd5);
            for (int i = 1; i < acc.size(); i++)
                chk("stream_period", 32'(acc[i] - acc[i-1]), 32'd10);
            chk("stream_overlap", 32'(overlap_cnt), 32'd0);
        end

        // Wide instance: all-ones with carry-in.
        a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        begin
            int w;
            w = 0;
            while (!out_valid16 && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            chk("w16_lat", 32'(w), 32'd16);
        end
        chk("w16_sum", 32'(sum16), 32'hFFFF);
        chk("w16_co", 32'(co16), 32'd1);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        chk("w16_in_ready", 32'(in_ready16), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: in_valid  input  1  operands a, b, ci valid.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  addend A.
REQ-007 Port: b  input  WIDTH  addend B.
REQ-008 Port: ci  input  1  carry-in.
REQ-009 Port: out_valid  output  1  sum and co valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: sum  output  WIDTH  result bits [WIDTH-1:0] of a+b+ci.
REQ-012 Port: co  output  1  carry-out, bit WIDTH of a+b+ci.

Function
REQ-013 The block SHALL compute {co,sum} = a + b + ci bit-serially, LSB first, one bit per clock, through one 1-bit full-adder cell.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1 and out_valid=0; on an edge with in_valid=1, the block SHALL capture a, b, ci into internal registers, clear the bit counter, and go to RUN.
REQ-016 RUN: in_ready=0 and out_valid=0; each edge SHALL add bit[count] of the captured A and B plus the carry register, write the sum bit to sum[count], update the carry register, and increment count.
REQ-017 RUN SHALL go to DONE on the edge that processes count=WIDTH-1; co SHALL take the final carry on that same edge.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-019 DONE: out_valid=1, in_ready=0; sum and co SHALL hold stable until the edge with out_ready=1, which returns the block to IDLE.
REQ-020 The block SHALL ignore in_valid outside IDLE; a, b, ci changes after capture SHALL NOT affect the result.
REQ-021 The block SHALL ignore out_ready outside DONE.
REQ-022 Back-to-back: in_ready SHALL assert in the cycle after the DONE handshake; the block SHALL NOT accept new operands in the same cycle as the DONE handshake.
REQ-023 Boundary: all-ones a and b with ci=1 SHALL give sum all-ones, co=1; zero operands with ci=0 SHALL give sum=0, co=0.
REQ-024 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-025 With rst_n=0 at a rising edge, the block SHALL enter IDLE, clear sum, co, the carry register, the counter and the operand registers to 0; outputs after that edge: in_ready=1, out_valid=0.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation without producing out_valid; no partial result SHALL remain visible.
REQ-027 rst_n SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-029 The 1-bit add SHALL be a separate combinational sub-module fa_cell (a, b, ci -> s, co); serial_adder SHALL instantiate exactly one.
REQ-030 in_ready and out_valid SHALL be decoded directly from the state register, with no combinational path from inputs.

Verification
REQ-031 WIDTH=8, a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1, out_valid exactly 8 cycles after accept.
REQ-032 WIDTH=8, exhaustive sweep of a, b, ci with out_ready=1 -> every {co,sum} equals a+b+ci; no result missing or duplicated.
REQ-033 WIDTH=8, result held with out_ready=0 for 5 cycles, a/b/in_valid toggled meanwhile -> sum, co and out_valid stable; in_ready=0.
REQ-034 WIDTH=8, rst_n=0 for one cycle at RUN bit 3 -> in_ready=1, out_valid=0, sum=0, co=0 next cycle; a following add of 8'h12+8'h34 gives 8'h46, co=0.
REQ-035 WIDTH=16, a=16'hFFFF, b=16'hFFFF, ci=1 -> sum=16'hFFFF, co=1, latency 16 cycles.
REQ-036 WIDTH=8, in_valid held high continuously with out_ready=1 -> one operation accepted per WIDTH+2 cycles, in_ready never high in RUN or DONE.
